// File: rtl/hyperbus_arb_pkg.sv
// Shared definitions for the hyperbus request-port arbiter: one-hot FSM
// encoding, default watchdog length and a constant-safe clog2.
package hyperbus_arb_pkg;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_ISSUE = 4'b0010,
        ST_WAIT  = 4'b0100,
        ST_DONE  = 4'b1000
    } arb_state_e;

    localparam int DEFAULT_TIMEOUT = 1023;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/hyperbus_rr_pick.sv
// Combinational round-robin picker: first set request bit strictly after
// last_grant, wrapping modulo NREQ.
module hyperbus_rr_pick #(
    parameter int NREQ = 2,
    parameter int IDXW = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] last_grant,
    output logic [NREQ-1:0] grant,
    output logic [IDXW-1:0] grant_idx,
    output logic            any
);

    logic [IDXW-1:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        cand      = '0;
        for (int off = 1; off <= NREQ; off++) begin
            cand = IDXW'((int'(last_grant) + off) % NREQ);
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant_idx   = cand;
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hyperbus_arbiter.sv
// Round-robin arbiter sharing one hyperbus_fifo request port between NREQ
// Wishbone-side requesters, one transaction at a time, with a wait watchdog.
module hyperbus_arbiter
    import hyperbus_arb_pkg::*;
#(
    parameter int NREQ           = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
    input  logic                       wb_clk,
    input  logic                       wb_rst,
    input  logic [NREQ-1:0]            req_i,
    input  logic [NREQ-1:0]            we_i,
    input  logic [NREQ*ADDR_WIDTH-1:0] adr_i,
    input  logic [NREQ*DATA_WIDTH-1:0] dat_i,
    output logic [NREQ-1:0]            gnt_o,
    output logic [NREQ-1:0]            ack_o,
    output logic [NREQ-1:0]            err_o,
    output logic [DATA_WIDTH-1:0]      dat_o,
    output logic                       busy_o,
    output logic                       rrq,
    output logic                       wrq,
    output logic [ADDR_WIDTH-1:0]      adr_o,
    output logic [DATA_WIDTH-1:0]      tx_dat_o,
    input  logic [DATA_WIDTH-1:0]      rx_dat_i,
    input  logic                       tx_ready,
    input  logic                       rx_valid,
    output logic [3:0]                 dbg_state
);

    // Handshake: req_i[i] is held until ack_o[i] or err_o[i]; rrq/wrq are
    // single-cycle strobes to the fifo, which answers with one rx_valid or
    // tx_ready strobe that is only honoured in WAIT for the matching direction.

    localparam int IDXW = (NREQ > 1) ? clog2(NREQ) : 1;
    localparam int CNTW = (TIMEOUT_CYCLES > 0) ? clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNTW-1:0] CNT_TERM = CNTW'(TIMEOUT_CYCLES);

    arb_state_e      state;
    logic [IDXW-1:0] last_grant;
    logic            owner_we;
    logic [IDXW-1:0] owner;
    logic [CNTW-1:0] wait_cnt;

    logic [NREQ-1:0] pick_gnt;
    logic [IDXW-1:0] pick_idx;
    logic            pick_any;

    hyperbus_rr_pick #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_pick (
        .req        (req_i),
        .last_grant (last_grant),
        .grant      (pick_gnt),
        .grant_idx  (pick_idx),
        .any        (pick_any)
    );

    assign dbg_state = state;

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state      <= ST_IDLE;
            last_grant <= IDXW'(NREQ - 1);
            owner      <= '0;
            owner_we   <= 1'b0;
            wait_cnt   <= '0;
            gnt_o      <= '0;
            ack_o      <= '0;
            err_o      <= '0;
            dat_o      <= '0;
            busy_o     <= 1'b0;
            rrq        <= 1'b0;
            wrq        <= 1'b0;
            adr_o      <= '0;
            tx_dat_o   <= '0;
        end else begin
            rrq   <= 1'b0;
            wrq   <= 1'b0;
            ack_o <= '0;
            err_o <= '0;
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        owner    <= pick_idx;
                        owner_we <= we_i[pick_idx];
                        adr_o    <= adr_i[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
                        tx_dat_o <= dat_i[pick_idx*DATA_WIDTH +: DATA_WIDTH];
                        gnt_o    <= pick_gnt;
                        busy_o   <= 1'b1;
                        state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    rrq      <= !owner_we;
                    wrq      <= owner_we;
                    wait_cnt <= '0;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Completion is tested first so it beats a same-cycle timeout.
                    if (owner_we ? tx_ready : rx_valid) begin
                        ack_o <= gnt_o;
                        if (!owner_we) begin
                            dat_o <= rx_dat_i;
                        end
                        state <= ST_DONE;
                    end else if (TIMEOUT_CYCLES != 0 && wait_cnt == CNT_TERM) begin
                        err_o <= gnt_o;
                        state <= ST_DONE;
                    end else if (wait_cnt != CNT_TERM) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    gnt_o      <= '0;
                    last_grant <= owner;
                    busy_o     <= 1'b0;
                    state      <= ST_IDLE;
                end
                default: begin
                    gnt_o  <= '0;
                    busy_o <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hyperbus_arbiter.sv
// Scoreboard bench for hyperbus_arbiter: directed transactions push expected
// ack/err/data; a negedge monitor pops and compares on every completion.
module tb_hyperbus_arbiter;

    localparam int EW = 37;  // {ack[1:0], err[1:0], check_data, data[31:0]}

    logic        wb_clk;
    logic        wb_rst;
    logic [1:0]  req_i;
    logic [1:0]  we_i;
    logic [63:0] adr_i;
    logic [63:0] dat_i;
    logic [1:0]  gnt_o;
    logic [1:0]  ack_o;
    logic [1:0]  err_o;
    logic [31:0] dat_o;
    logic        busy_o;
    logic        rrq;
    logic        wrq;
    logic [31:0] adr_o;
    logic [31:0] tx_dat_o;
    logic [31:0] rx_dat_i;
    logic        tx_ready;
    logic        rx_valid;
    logic [3:0]  dbg_state;

    int          n_tests;
    int          n_fail;
    logic [EW-1:0] exp_q[$];

    int          fifo_delay;
    bit          fifo_respond;
    bit          fifo_rx_wr;
    logic [31:0] rsp_data;

    hyperbus_arbiter #(
        .NREQ           (2),
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (15)
    ) dut (
        .wb_clk    (wb_clk),
        .wb_rst    (wb_rst),
        .req_i     (req_i),
        .we_i      (we_i),
        .adr_i     (adr_i),
        .dat_i     (dat_i),
        .gnt_o     (gnt_o),
        .ack_o     (ack_o),
        .err_o     (err_o),
        .dat_o     (dat_o),
        .busy_o    (busy_o),
        .rrq       (rrq),
        .wrq       (wrq),
        .adr_o     (adr_o),
        .tx_dat_o  (tx_dat_o),
        .rx_dat_i  (rx_dat_i),
        .tx_ready  (tx_ready),
        .rx_valid  (rx_valid),
        .dbg_state (dbg_state)
    );

    // Clock and watchdog
    initial begin
        wb_clk = 1'b0;
        forever #5 wb_clk = ~wb_clk;
    end

    initial begin
        #200000;
        $display("FAIL sim_timeout: simulation exceeded time limit");
        $fatal(1, "simulation timeout");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
        end
    endtask

    // Fifo model: answers rrq/wrq fifo_delay cycles after seeing the strobe.
    initial begin
        int cnt;
        bit pend;
        bit is_rd;
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        rx_dat_i = '0;
        pend     = 1'b0;
        cnt      = 0;
        is_rd    = 1'b0;
        forever begin
            @(posedge wb_clk);
            #1;
            rx_valid = 1'b0;
            tx_ready = 1'b0;
            if (pend) begin
                if (fifo_rx_wr && !is_rd && cnt == 2) begin
                    rx_valid = 1'b1;
                    rx_dat_i = 32'hBAD0_BAD0;
                end
                if (cnt <= 1) begin
                    if (is_rd) begin
                        rx_valid = 1'b1;
                        rx_dat_i = rsp_data;
                    end else begin
                        tx_ready = 1'b1;
                    end
                    pend = 1'b0;
                end else begin
                    cnt--;
                end
            end
            if ((rrq || wrq) && fifo_respond) begin
                pend  = 1'b1;
                cnt   = fifo_delay;
                is_rd = rrq;
            end
        end
    end

    // Monitor: every completion pulse must match the head of the queue.
    initial begin
        logic [EW-1:0] e;
        forever begin
            @(negedge wb_clk);
            if (!wb_rst && (ack_o != 2'b00 || err_o != 2'b00)) begin
                if (exp_q.size() == 0) begin
                    check("mon_unexpected", 64'({ack_o, err_o}), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("mon_ack", 64'(ack_o), 64'(e[36:35]));
                    check("mon_err", 64'(err_o), 64'(e[34:33]));
                    if (e[32]) check("mon_rdata", 64'(dat_o), 64'(e[31:0]));
                end
            end
        end
    end

    function automatic logic [EW-1:0] mk_exp(input int idx, input bit we, input bit is_err,
                                             input logic [31:0] d);
        logic [1:0] oh;
        oh = 2'b01 << idx;
        return {is_err ? 2'b00 : oh, is_err ? oh : 2'b00, !we && !is_err, d};
    endfunction

    // One transaction from requester idx; lat counts cycles from the rrq/wrq
    // cycle to the ack/err cycle.
    task automatic do_txn(input int idx, input bit we, input logic [31:0] adr,
                          input logic [31:0] wd, input int delay, input bit respond,
                          input bit rx_wr, input bit exp_err,
                          output int lat, output int n_rrq, output int n_wrq,
                          output logic [31:0] s_adr, output logic [31:0] s_tx,
                          output logic [1:0] s_gnt, output logic s_busy_t,
                          output logic s_busy_n);
        int  t_iss;
        bit  done;
        fifo_delay   = delay;
        fifo_respond = respond;
        fifo_rx_wr   = rx_wr;
        adr_i[idx*32 +: 32] = adr;
        dat_i[idx*32 +: 32] = wd;
        we_i[idx]    = we;
        req_i[idx]   = 1'b1;
        exp_q.push_back(mk_exp(idx, we, exp_err, rsp_data));
        n_rrq = 0; n_wrq = 0; t_iss = 0; lat = -1; done = 0;
        s_adr = '0; s_tx = '0; s_gnt = '0; s_busy_t = 1'b0; s_busy_n = 1'b1;
        for (int t = 0; t < 100 && !done; t++) begin
            @(posedge wb_clk);
            #1;
            if (t == 0) s_gnt = gnt_o;
            if (rrq || wrq) begin
                t_iss = t;
                s_adr = adr_o;
                s_tx  = tx_dat_o;
            end
            if (rrq) n_rrq++;
            if (wrq) n_wrq++;
            if (ack_o != 2'b00 || err_o != 2'b00) begin
                lat        = t - t_iss;
                s_busy_t   = busy_o;
                req_i[idx] = 1'b0;
                done       = 1;
            end
        end
        if (!done) begin
            check("txn_bound", 64'(0), 64'(1));
            req_i[idx] = 1'b0;
            exp_q.delete();
        end
        @(posedge wb_clk);
        #1;
        s_busy_n = busy_o;
        @(posedge wb_clk);
        #1;
    endtask

    initial begin
        int          lat;
        int          nr;
        int          nw;
        int          served;
        int          bad;
        logic [31:0] sa;
        logic [31:0] st;
        logic [1:0]  sg;
        logic [1:0]  pend;
        logic [1:0]  first;
        logic        bt;
        logic        bn;

        n_tests = 0; n_fail = 0;
        wb_rst = 1'b1; req_i = '0; we_i = '0; adr_i = '0; dat_i = '0;
        fifo_delay = 1; fifo_respond = 1'b1; fifo_rx_wr = 1'b0; rsp_data = '0;

        repeat (3) @(posedge wb_clk);
        #1;
        check("rst_gnt", 64'(gnt_o), 64'(0));
        check("rst_pulses", 64'({ack_o, err_o, rrq, wrq, busy_o}), 64'(0));
        check("rst_adr_tx", 64'({adr_o, tx_dat_o}), 64'(0));
        check("rst_dat", 64'(dat_o), 64'(0));
        check("rst_state", 64'(dbg_state), 64'(4'b0001));
        wb_rst = 1'b0;

        // Single read, fifo answers one cycle after rrq.
        rsp_data = 32'hDEAD_BEEF;
        do_txn(0, 1'b0, 32'h0000_0100, 32'h0, 1, 1'b1, 1'b0, 1'b0, lat, nr, nw, sa, st, sg, bt, bn);
        check("rd_gnt", 64'(sg), 64'(2'b01));
        check("rd_rrq_count", 64'(nr), 64'(1));
        check("rd_wrq_count", 64'(nw), 64'(0));
        check("rd_adr", 64'(sa), 64'(32'h0000_0100));
        check("rd_latency", 64'(lat), 64'(2));

        // Single write, tx_ready five cycles after wrq.
        do_txn(1, 1'b1, 32'h0000_0200, 32'h1234_5678, 5, 1'b1, 1'b0, 1'b0, lat, nr, nw, sa, st, sg, bt, bn);
        check("wr_gnt", 64'(sg), 64'(2'b10));
        check("wr_wrq_count", 64'(nw), 64'(1));
        check("wr_rrq_count", 64'(nr), 64'(0));
        check("wr_tx_dat", 64'(st), 64'(32'h1234_5678));
        check("wr_latency", 64'(lat), 64'(6));
        check("wr_dat_o_held", 64'(dat_o), 64'(32'hDEAD_BEEF));

        // Fairness: both held, each drops for one cycle after its ack.
        rsp_data = 32'h0F0F_0001;
        fifo_delay = 1; fifo_respond = 1'b1; fifo_rx_wr = 1'b0;
        we_i = 2'b00;
        adr_i = {32'h0000_1100, 32'h0000_1000};
        for (int k = 0; k < 8; k++) exp_q.push_back(mk_exp(k % 2, 1'b0, 1'b0, rsp_data));
        req_i = 2'b11; pend = 2'b00; served = 0;
        for (int c = 0; c < 200 && served < 8; c++) begin
            @(posedge wb_clk);
            #1;
            if (pend != 2'b00) begin
                req_i = req_i | pend;
                pend  = 2'b00;
            end
            if (ack_o != 2'b00) begin
                req_i = req_i & ~ack_o;
                pend  = ack_o;
                served++;
            end
        end
        req_i = 2'b00;
        check("fair_served", 64'(served), 64'(8));
        repeat (6) @(posedge wb_clk);
        #1;

        // Watchdog: no fifo answer, err 16 cycles after rrq.
        do_txn(0, 1'b0, 32'h0000_0400, 32'h0, 1, 1'b0, 1'b0, 1'b1, lat, nr, nw, sa, st, sg, bt, bn);
        check("to_rrq_count", 64'(nr), 64'(1));
        check("to_latency", 64'(lat), 64'(16));
        check("to_busy_at_err", 64'(bt), 64'(1));
        check("to_busy_after", 64'(bn), 64'(0));

        // Next request after a timeout is served normally.
        rsp_data = 32'hCAFE_0001;
        do_txn(1, 1'b0, 32'h0000_0500, 32'h0, 2, 1'b1, 1'b0, 1'b0, lat, nr, nw, sa, st, sg, bt, bn);
        check("post_to_latency", 64'(lat), 64'(3));
        check("post_to_adr", 64'(sa), 64'(32'h0000_0500));

        // tx_ready on the terminal-count cycle: completion wins.
        do_txn(1, 1'b1, 32'h0000_0600, 32'hA5A5_5A5A, 15, 1'b1, 1'b0, 1'b0, lat, nr, nw, sa, st, sg, bt, bn);
        check("race_latency", 64'(lat), 64'(16));

        // rx_valid during a write is ignored; dat_o keeps the last read data.
        do_txn(0, 1'b1, 32'h0000_0700, 32'h0BAD_CAFE, 4, 1'b1, 1'b1, 1'b0, lat, nr, nw, sa, st, sg, bt, bn);
        check("rxw_latency", 64'(lat), 64'(5));
        check("rxw_dat_o", 64'(dat_o), 64'(32'hCAFE_0001));
        check("rxw_tx_dat", 64'(st), 64'(32'h0BAD_CAFE));

        // Reset in WAIT; the late rx_valid lands in IDLE.
        fifo_delay = 6; fifo_respond = 1'b1; fifo_rx_wr = 1'b0;
        we_i = 2'b00; adr_i[32 +: 32] = 32'h0000_0800; req_i = 2'b10;
        repeat (3) @(posedge wb_clk);
        #1;
        check("mid_state_wait", 64'(dbg_state), 64'(4'b0100));
        wb_rst = 1'b1; req_i = 2'b00;
        @(posedge wb_clk);
        #1;
        wb_rst = 1'b0;
        check("mid_rst_state", 64'(dbg_state), 64'(4'b0001));
        check("mid_rst_outs", 64'({gnt_o, ack_o, err_o, rrq, wrq, busy_o}), 64'(0));
        check("mid_rst_data", 64'({adr_o, dat_o}), 64'(0));
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge wb_clk);
            #1;
            if (ack_o != 2'b00 || err_o != 2'b00 || busy_o) bad++;
        end
        check("mid_rst_stray", 64'(bad), 64'(0));

        // Tie after reset: requester 0 first, then 1.
        rsp_data = 32'h7777_0000; fifo_delay = 1;
        adr_i = {32'h0000_0A00, 32'h0000_0900};
        exp_q.push_back(mk_exp(0, 1'b0, 1'b0, rsp_data));
        exp_q.push_back(mk_exp(1, 1'b0, 1'b0, rsp_data));
        req_i = 2'b11; first = 2'b00;
        for (int c = 0; c < 60 && req_i != 2'b00; c++) begin
            @(posedge wb_clk);
            #1;
            if (ack_o != 2'b00 || err_o != 2'b00) begin
                if (first == 2'b00) first = ack_o | err_o;
                req_i = req_i & ~(ack_o | err_o);
            end
        end
        req_i = 2'b00;
        check("tie_first", 64'(first), 64'(2'b01));
        repeat (4) @(posedge wb_clk);
        #1;
        check("queue_empty", 64'(exp_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
